// File: rtl/interval_timer_arbiter_pkg.sv
// Shared types and helpers for the interval timer arbiter.
// Holds the FSM state encoding and the log2 helper that sizes requester indices.
package interval_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// Elapsed-cycle counter for one interval: clears on request, counts when enabled,
// and flags the last RUN cycle (count == dur - 1).
module interval_counter #(
  parameter int NBITS_DUR = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync_clear,
  input  logic [NBITS_DUR-1:0] dur,
  output logic [NBITS_DUR-1:0] count,
  output logic                 terminal
);

  localparam logic [NBITS_DUR-1:0] ONE = NBITS_DUR'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (sync_clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  assign terminal = (count == (dur - ONE));

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter that grants one requester at a time for a timed interval,
// pulsing done to that requester when its interval expires.
module interval_timer_arbiter
  import interval_timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NBITS_DUR = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*NBITS_DUR-1:0]   duration,
  input  logic                           abort,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [NBITS_DUR-1:0]           count
);

  localparam int IDX_W = (CeilLog2(NUM_REQ) < 1) ? 1 : CeilLog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

  state_t               state;
  state_t               next_state;
  logic [IDX_W-1:0]     last_served;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     pick_idx;
  logic [NBITS_DUR-1:0] dur_reg;
  logic [NBITS_DUR-1:0] sel_dur;
  logic                 any_req;
  logic                 terminal;
  logic                 ctr_enable;
  logic                 ctr_clear;
  logic                 end_interval;

  // Walk downward so the closest candidate after last_served wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    int               cand;
    pick = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (r[cand]) pick = IDX_W'(cand);
    end
    return pick;
  endfunction

  assign any_req  = |req;
  assign pick_idx = rr_pick(req, last_served);
  assign sel_dur  = duration[int'(gnt_idx) * NBITS_DUR +: NBITS_DUR];

  assign end_interval = (state == DONE) ||
                        (((state == LOAD) || (state == RUN)) && abort);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (any_req) next_state = LOAD;
      LOAD: begin
        if (abort)              next_state = IDLE;
        else if (sel_dur == '0) next_state = DONE;
        else                    next_state = RUN;
      end
      RUN: begin
        if (abort)         next_state = IDLE;
        else if (terminal) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_idx     <= '0;
      dur_reg     <= '0;
      last_served <= LAST_INIT;
    end else begin
      state <= next_state;
      if ((state == IDLE) && any_req) begin
        gnt     <= GNT_ONE << pick_idx;
        gnt_idx <= pick_idx;
      end
      if (state == LOAD) begin
        dur_reg <= sel_dur;
      end
      if (end_interval) begin
        gnt         <= '0;
        last_served <= gnt_idx;
      end
    end
  end

  // The terminal cycle does not increment, so count settles at dur_reg-1.
  assign ctr_clear  = (state == LOAD);
  assign ctr_enable = (state == RUN) && !terminal;

  interval_counter #(
    .NBITS_DUR (NBITS_DUR)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .enable     (ctr_enable),
    .sync_clear (ctr_clear),
    .dur        (dur_reg),
    .count      (count),
    .terminal   (terminal)
  );

  assign done = (state == DONE) ? gnt : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter: cycle-exact checks in the main sequence
// plus a scoreboard of expected done pulses drained by a monitor.
module tb_interval_timer_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int NBITS_DUR = 8;

  typedef struct packed {
    logic [NUM_REQ-1:0]   done;
    logic [NBITS_DUR-1:0] count;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*NBITS_DUR-1:0] duration;
  logic                         abort;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic [NBITS_DUR-1:0]         count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_exp;

  interval_timer_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .NBITS_DUR (NBITS_DUR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .duration (duration),
    .abort    (abort),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] new_req, input logic new_abort);
    req   = new_req;
    abort = new_abort;
  endtask

  task automatic setDuration(input int idx, input logic [NBITS_DUR-1:0] val);
    duration[idx*NBITS_DUR +: NBITS_DUR] = val;
  endtask

  task automatic expectDone(input logic [NUM_REQ-1:0] d, input logic [NBITS_DUR-1:0] c);
    exp_t e;
    e.done  = d;
    e.count = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called from an IDLE cycle with req already driven; returns in the IDLE cycle after DONE.
  task automatic runInterval(input logic [NUM_REQ-1:0] exp_gnt, input int d, input bit disturb);
    tick();
    checkOutput("load_gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("load_busy", 32'(busy), 1);
    checkOutput("load_done", 32'(done), 0);
    for (int k = 0; k < d; k++) begin
      tick();
      checkOutput("run_count", 32'(count), k);
      checkOutput("run_gnt", 32'(gnt), 32'(exp_gnt));
      if (disturb && k == 1) begin
        req      = '0;
        duration = ~duration;
      end
    end
    tick();
    checkOutput("done_pulse", 32'(done), 32'(exp_gnt));
    checkOutput("done_gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("done_count", 32'(count), (d == 0) ? 0 : d - 1);
    tick();
    checkOutput("idle_gnt", 32'(gnt), 0);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_done", 32'(done), 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && done !== '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 0);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("sb_done", 32'(done), 32'(mon_exp.done));
        checkOutput("sb_count", 32'(count), 32'(mon_exp.count));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    reset    = 1'b0;
    req      = '0;
    duration = '0;
    abort    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt", 32'(gnt), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_count", 32'(count), 0);
    reset = 1'b1;
    tick();
    checkOutput("idle_no_req_busy", 32'(busy), 0);
    checkOutput("idle_no_req_gnt", 32'(gnt), 0);

    $display("[TB] single request, duration 5");
    setDuration(0, 8'd5);
    applyStimulus(4'b0001, 1'b0);
    expectDone(4'b0001, 8'd4);
    runInterval(4'b0001, 5, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] round-robin fairness");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) setDuration(i, 8'd2);
    applyStimulus(4'b1111, 1'b0);
    for (int t = 0; t < 5; t++) expectDone(4'b0001 << (t % 4), 8'd1);
    for (int t = 0; t < 5; t++) runInterval(4'b0001 << (t % 4), 2, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] zero duration");
    setDuration(2, 8'd0);
    applyStimulus(4'b0100, 1'b0);
    expectDone(4'b0100, 8'd0);
    runInterval(4'b0100, 0, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] abort at count 3");
    setDuration(1, 8'd10);
    setDuration(2, 8'd1);
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("abort_load_gnt", 32'(gnt), 32'(4'b0010));
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("abort_run_count", 32'(count), k);
    end
    applyStimulus(4'b0010, 1'b1);
    tick();
    checkOutput("abort_idle_gnt", 32'(gnt), 0);
    checkOutput("abort_idle_busy", 32'(busy), 0);
    checkOutput("abort_idle_done", 32'(done), 0);
    applyStimulus(4'b1111, 1'b0);
    expectDone(4'b0100, 8'd0);
    runInterval(4'b0100, 1, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("abort_in_idle_busy", 32'(busy), 0);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] req and duration change mid-run");
    setDuration(3, 8'd4);
    applyStimulus(4'b1000, 1'b0);
    expectDone(4'b1000, 8'd3);
    runInterval(4'b1000, 4, 1'b1);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] reset mid-run, then maximum duration");
    duration = '0;
    setDuration(0, 8'd20);
    applyStimulus(4'b0001, 1'b0);
    repeat (3) tick();
    checkOutput("pre_reset_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_gnt", 32'(gnt), 0);
    checkOutput("midreset_done", 32'(done), 0);
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_count", 32'(count), 0);
    applyStimulus(4'b0000, 1'b0);
    tick();
    reset = 1'b1;
    setDuration(0, 8'd255);
    applyStimulus(4'b0001, 1'b0);
    expectDone(4'b0001, 8'd254);
    runInterval(4'b0001, 255, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    tick();
    checkOutput("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
